// File: rtl/ov5640_cap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_cap_ctrl_if
// Description : Session control, packed-pixel input and FIFO write bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface ov5640_cap_ctrl_if;
  logic        cap_start;
  logic        cap_stop;
  logic [7:0]  frame_num;
  logic        vsync_in;
  logic        href_in;
  logic        pix_wr_en;
  logic [15:0] pix_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        err_ovf;
  logic        err_size;

  modport master (
    output cap_start, cap_stop, frame_num, vsync_in, href_in,
           pix_wr_en, pix_data, fifo_full,
    input  fifo_wr_en, fifo_wr_data, busy, frame_done, frame_cnt,
           err_ovf, err_size
  );

  modport slave (
    input  cap_start, cap_stop, frame_num, vsync_in, href_in,
           pix_wr_en, pix_data, fifo_full,
    output fifo_wr_en, fifo_wr_data, busy, frame_done, frame_cnt,
           err_ovf, err_size
  );
endinterface
`default_nettype wire

// File: rtl/ov5640_cap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_cap_ctrl
// Description : Capture session FSM gating packed pixels into a write FIFO,
//               with frame counting and geometry / overflow error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ov5640_cap_ctrl #(
  parameter int H_PIXEL = 640,
  parameter int V_LINE  = 480
) (
  input  wire logic         ov5640_pclk,
  input  wire logic         sys_rst_n,
  ov5640_cap_ctrl_if.slave  cap_if
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_ARM     = 2'd1;
  localparam logic [1:0]  S_CAPTURE = 2'd2;
  localparam logic [11:0] c_h_pixel = 12'(H_PIXEL);
  localparam logic [10:0] c_v_line  = 11'(V_LINE);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        r_vs_d;
  logic        r_href_d;
  logic [7:0]  r_frame_num;
  logic        r_stop_pend;
  logic [11:0] r_pix_cnt;
  logic [10:0] r_line_cnt;
  logic        r_line_bad;

  logic        w_vs_rise;
  logic        w_href_fall;
  logic [7:0]  w_cnt_next;
  logic        w_last_frame;
  logic        w_busy;
  logic        w_capture;
  logic        w_start_ok;
  logic        w_frame_end;
  logic        w_arm_go;
  logic        w_wr_ok;

  assign w_vs_rise    = cap_if.vsync_in & ~r_vs_d;
  assign w_href_fall  = ~cap_if.href_in & r_href_d;
  assign w_cnt_next   = cap_if.frame_cnt + 8'd1;
  assign w_last_frame = (r_frame_num != 8'd0) && (w_cnt_next == r_frame_num);

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (cap_if.cap_start && !cap_if.cap_stop) w_state_next = S_ARM;
      S_ARM: begin
        if (cap_if.cap_stop) w_state_next = S_IDLE;
        else if (w_vs_rise)  w_state_next = S_CAPTURE;
      end
      S_CAPTURE: if (w_vs_rise && (r_stop_pend || w_last_frame)) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_capture   = (r_state == S_CAPTURE);
    w_start_ok  = (r_state == S_IDLE) && cap_if.cap_start && !cap_if.cap_stop;
    w_arm_go    = (r_state == S_ARM) && !cap_if.cap_stop && w_vs_rise;
    w_frame_end = w_capture && w_vs_rise;
    w_wr_ok     = w_capture && cap_if.pix_wr_en && !cap_if.fifo_full;
  end

  assign cap_if.busy = w_busy;

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vs_d              <= 1'b0;
      r_href_d            <= 1'b0;
      r_frame_num         <= 8'd0;
      r_stop_pend         <= 1'b0;
      r_pix_cnt           <= 12'd0;
      r_line_cnt          <= 11'd0;
      r_line_bad          <= 1'b0;
      cap_if.fifo_wr_en   <= 1'b0;
      cap_if.fifo_wr_data <= 16'd0;
      cap_if.frame_done   <= 1'b0;
      cap_if.frame_cnt    <= 8'd0;
      cap_if.err_ovf      <= 1'b0;
      cap_if.err_size     <= 1'b0;
    end else begin
      r_vs_d            <= cap_if.vsync_in;
      r_href_d          <= cap_if.href_in;
      cap_if.fifo_wr_en <= w_wr_ok;
      cap_if.frame_done <= w_frame_end;
      if (w_wr_ok) cap_if.fifo_wr_data <= cap_if.pix_data;

      if (w_start_ok) begin
        r_frame_num      <= cap_if.frame_num;
        r_stop_pend      <= 1'b0;
        cap_if.frame_cnt <= 8'd0;
        cap_if.err_ovf   <= 1'b0;
        cap_if.err_size  <= 1'b0;
      end

      if (w_capture && cap_if.cap_stop) r_stop_pend <= 1'b1;
      if (w_capture && cap_if.pix_wr_en && cap_if.fifo_full) cap_if.err_ovf <= 1'b1;

      // The closing vs_rise of one frame is also the opening edge of the next.
      if (w_arm_go || w_frame_end) begin
        r_pix_cnt  <= 12'd0;
        r_line_cnt <= 11'd0;
        r_line_bad <= 1'b0;
      end else if (w_capture) begin
        if (w_href_fall && (r_pix_cnt != 12'd0)) begin
          if (r_line_cnt != 11'h7FF) r_line_cnt <= r_line_cnt + 11'd1;
          if (r_pix_cnt != c_h_pixel) r_line_bad <= 1'b1;
          r_pix_cnt <= 12'd0;
        end else if (cap_if.pix_wr_en && (r_pix_cnt != 12'hFFF)) begin
          r_pix_cnt <= r_pix_cnt + 12'd1;
        end
      end

      if (w_frame_end) begin
        cap_if.frame_cnt <= w_cnt_next;
        if (r_line_bad || (r_line_cnt != c_v_line)) cap_if.err_size <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ov5640_cap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov5640_cap_ctrl
// Description : Directed scoreboard bench for ov5640_cap_ctrl (4x2 frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov5640_cap_ctrl;

  logic clk;
  logic rst_n;
  ov5640_cap_ctrl_if cap_if ();

  ov5640_cap_ctrl #(.H_PIXEL(4), .V_LINE(2)) dut (
    .ov5640_pclk (clk),
    .sys_rst_n   (rst_n),
    .cap_if      (cap_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks     = 0;
  int          errors     = 0;
  int          mon_checks = 0;
  int          mon_errors = 0;
  logic [15:0] wr_q[$];
  logic [8:0]  fd_q[$];
  logic [15:0] next_data  = 16'h1000;
  logic        prev_pix   = 1'b0;
  logic [15:0] exp_wr;
  logic [8:0]  exp_fd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic with_stop);
    cap_if.cap_start = 1'b1;
    cap_if.cap_stop  = with_stop;
    tick();
    cap_if.cap_start = 1'b0;
    cap_if.cap_stop  = 1'b0;
  endtask

  task automatic pulse_stop();
    cap_if.cap_stop = 1'b1;
    tick();
    cap_if.cap_stop = 1'b0;
  endtask

  task automatic vs_pulse(input bit exp_done, input logic [8:0] exp_val);
    if (exp_done) fd_q.push_back(exp_val);
    cap_if.vsync_in = 1'b1;
    tick();
    tick();
    cap_if.vsync_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic drive_line(input int n, input logic [3:0] full_mask, input bit exp_cap);
    cap_if.href_in = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      cap_if.pix_wr_en = 1'b1;
      cap_if.pix_data  = next_data;
      cap_if.fifo_full = full_mask[i];
      if (exp_cap && !full_mask[i]) wr_q.push_back(next_data);
      next_data = next_data + 16'h0011;
      tick();
    end
    cap_if.pix_wr_en = 1'b0;
    cap_if.fifo_full = 1'b0;
    tick();
    cap_if.href_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_drained(input string name);
    check({name, "_writes_left"}, 16'(wr_q.size()), 16'd0);
    check({name, "_frames_left"}, 16'(fd_q.size()), 16'd0);
  endtask

  always @(negedge clk) begin
    if (cap_if.fifo_wr_en) begin
      mon_checks++;
      if (wr_q.size() == 0) begin
        mon_errors++;
        $display("FAIL unexpected_write: got data %0h, expected no write", cap_if.fifo_wr_data);
      end else begin
        exp_wr = wr_q.pop_front();
        if (cap_if.fifo_wr_data !== exp_wr || !prev_pix) begin
          mon_errors++;
          $display("FAIL write_data: got %0h (pix_wr_en prior cycle %0b), expected %0h with prior strobe 1",
                   cap_if.fifo_wr_data, prev_pix, exp_wr);
        end
      end
    end
    if (cap_if.frame_done) begin
      mon_checks++;
      if (fd_q.size() == 0) begin
        mon_errors++;
        $display("FAIL unexpected_frame_done: got frame_cnt %0d, expected no frame_done", cap_if.frame_cnt);
      end else begin
        exp_fd = fd_q.pop_front();
        if ({cap_if.err_size, cap_if.frame_cnt} !== exp_fd) begin
          mon_errors++;
          $display("FAIL frame_done: got err_size=%0b frame_cnt=%0d, expected err_size=%0b frame_cnt=%0d",
                   cap_if.err_size, cap_if.frame_cnt, exp_fd[8], exp_fd[7:0]);
        end
      end
    end
    prev_pix = cap_if.pix_wr_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    cap_if.cap_start = 1'b0;
    cap_if.cap_stop  = 1'b0;
    cap_if.frame_num = 8'd0;
    cap_if.vsync_in  = 1'b0;
    cap_if.href_in   = 1'b0;
    cap_if.pix_wr_en = 1'b0;
    cap_if.pix_data  = 16'd0;
    cap_if.fifo_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    check("rst_busy", 16'(cap_if.busy), 16'd0);
    check("rst_wr_en", 16'(cap_if.fifo_wr_en), 16'd0);
    check("rst_frame_cnt", 16'(cap_if.frame_cnt), 16'd0);
    check("rst_err", 16'({cap_if.err_ovf, cap_if.err_size}), 16'd0);

    // Single frame, frame_num = 1
    cap_if.frame_num = 8'd1;
    pulse_start(1'b0);
    check("t1_busy_arm", 16'(cap_if.busy), 16'd1);
    vs_pulse(1'b0, 9'd0);
    drive_line(4, 4'b0000, 1'b1);
    drive_line(4, 4'b0000, 1'b1);
    vs_pulse(1'b1, {1'b0, 8'd1});
    check("t1_busy_done", 16'(cap_if.busy), 16'd0);
    check("t1_frame_cnt", 16'(cap_if.frame_cnt), 16'd1);
    check("t1_err", 16'({cap_if.err_ovf, cap_if.err_size}), 16'd0);
    check_drained("t1");

    // Continuous session stopped during frame 3
    cap_if.frame_num = 8'd0;
    pulse_start(1'b0);
    vs_pulse(1'b0, 9'd0);
    drive_line(4, 4'b0000, 1'b1);
    drive_line(4, 4'b0000, 1'b1);
    vs_pulse(1'b1, {1'b0, 8'd1});
    drive_line(4, 4'b0000, 1'b1);
    drive_line(4, 4'b0000, 1'b1);
    vs_pulse(1'b1, {1'b0, 8'd2});
    check("t2_busy_f2", 16'(cap_if.busy), 16'd1);
    drive_line(4, 4'b0000, 1'b1);
    pulse_stop();
    check("t2_busy_stop_pend", 16'(cap_if.busy), 16'd1);
    drive_line(4, 4'b0000, 1'b1);
    check("t2_busy_before_vs", 16'(cap_if.busy), 16'd1);
    vs_pulse(1'b1, {1'b0, 8'd3});
    check("t2_busy_done", 16'(cap_if.busy), 16'd0);
    check("t2_frame_cnt", 16'(cap_if.frame_cnt), 16'd3);
    check_drained("t2");

    // Two pixels dropped on fifo_full
    cap_if.frame_num = 8'd1;
    pulse_start(1'b0);
    vs_pulse(1'b0, 9'd0);
    drive_line(4, 4'b0110, 1'b1);
    drive_line(4, 4'b0000, 1'b1);
    vs_pulse(1'b1, {1'b0, 8'd1});
    check("t3_err_ovf", 16'(cap_if.err_ovf), 16'd1);
    check("t3_err_size", 16'(cap_if.err_size), 16'd0);
    check_drained("t3");

    // Short line gives err_size; next start clears it
    pulse_start(1'b0);
    check("t4_ovf_cleared", 16'(cap_if.err_ovf), 16'd0);
    vs_pulse(1'b0, 9'd0);
    drive_line(3, 4'b0000, 1'b1);
    drive_line(4, 4'b0000, 1'b1);
    vs_pulse(1'b1, {1'b1, 8'd1});
    check("t4_err_size", 16'(cap_if.err_size), 16'd1);
    check("t4_busy", 16'(cap_if.busy), 16'd0);
    pulse_start(1'b0);
    check("t4_err_size_cleared", 16'(cap_if.err_size), 16'd0);
    pulse_stop();
    check("t4_busy_stopped", 16'(cap_if.busy), 16'd0);
    check_drained("t4");

    // start+stop together, then stop while armed
    pulse_start(1'b1);
    check("t5_busy_start_stop", 16'(cap_if.busy), 16'd0);
    pulse_start(1'b0);
    check("t5_busy_arm", 16'(cap_if.busy), 16'd1);
    drive_line(4, 4'b0000, 1'b0);
    pulse_stop();
    check("t5_busy_arm_stop", 16'(cap_if.busy), 16'd0);
    check_drained("t5");

    // Asynchronous reset mid-line of frame 2
    cap_if.frame_num = 8'd0;
    pulse_start(1'b0);
    vs_pulse(1'b0, 9'd0);
    drive_line(4, 4'b0000, 1'b1);
    drive_line(4, 4'b0000, 1'b1);
    vs_pulse(1'b1, {1'b0, 8'd1});
    cap_if.href_in = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      cap_if.pix_wr_en = 1'b1;
      cap_if.pix_data  = next_data;
      wr_q.push_back(next_data);
      next_data = next_data + 16'h0011;
      tick();
    end
    cap_if.pix_wr_en = 1'b0;
    tick();
    cap_if.pix_wr_en = 1'b1;
    cap_if.pix_data  = next_data;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 16'(cap_if.busy), 16'd0);
    check("t6_rst_wr_en", 16'(cap_if.fifo_wr_en), 16'd0);
    check("t6_rst_wr_data", cap_if.fifo_wr_data, 16'd0);
    check("t6_rst_frame_done", 16'(cap_if.frame_done), 16'd0);
    check("t6_rst_frame_cnt", 16'(cap_if.frame_cnt), 16'd0);
    check("t6_rst_err", 16'({cap_if.err_ovf, cap_if.err_size}), 16'd0);
    cap_if.vsync_in = 1'b1;
    tick();
    tick();
    cap_if.vsync_in  = 1'b0;
    cap_if.pix_wr_en = 1'b0;
    cap_if.href_in   = 1'b0;
    rst_n = 1'b1;
    tick();
    vs_pulse(1'b0, 9'd0);
    drive_line(4, 4'b0000, 1'b0);
    check("t6_busy_after_rst", 16'(cap_if.busy), 16'd0);
    pulse_start(1'b0);
    drive_line(4, 4'b0000, 1'b0);
    vs_pulse(1'b0, 9'd0);
    drive_line(4, 4'b0000, 1'b1);
    pulse_stop();
    vs_pulse(1'b1, {1'b1, 8'd1});
    check("t6_busy_end", 16'(cap_if.busy), 16'd0);
    tick();
    check_drained("t6");

    errors = errors + mon_errors;
    checks = checks + mon_checks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ov5640_cap_ctrl.md
OV5640_CAP_CTRL -- requirements
Module: ov5640_cap_ctrl

Interface
REQ-001 Parameter H_PIXEL, default 640: required 16-bit pixels per line.
REQ-002 Parameter V_LINE, default 480: required lines per frame.
REQ-003 ov5640_pclk  input  1  capture clock; all logic on its rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cap_start  input  1  one-cycle pulse that starts a capture session.
REQ-006 cap_stop  input  1  one-cycle pulse that requests the session to end.
REQ-007 frame_num  input  8  frames per session, sampled at cap_start; 0 means continuous.
REQ-008 vsync_in  input  1  frame sync from the pixel packer; its rising edge is the frame boundary.
REQ-009 href_in  input  1  line-valid from the pixel packer.
REQ-010 pix_wr_en  input  1  packed-pixel valid strobe.
REQ-011 pix_data  input  16  packed pixel.
REQ-012 fifo_full  input  1  downstream write-FIFO full.
REQ-013 fifo_wr_en  output  1  write strobe to the FIFO.
REQ-014 fifo_wr_data  output  16  write data to the FIFO.
REQ-015 busy  output  1  high when state is not IDLE.
REQ-016 frame_done  output  1  one-cycle pulse at each completed frame.
REQ-017 frame_cnt  output  8  frames completed in the current session.
REQ-018 err_ovf  output  1  sticky flag: a pixel was dropped because the FIFO was full.
REQ-019 err_size  output  1  sticky flag: a completed frame had the wrong geometry.

Function
REQ-020 vs_rise SHALL be vsync_in high while a registered copy of vsync_in is low; href_fall is defined the same way with the polarity reversed.
REQ-021 The FSM SHALL have three states: IDLE, ARM and CAPTURE.
REQ-022 IDLE->ARM SHALL occur on cap_start without cap_stop; frame_num is latched, frame_cnt, err_ovf and err_size are cleared, and the stop request is cleared.
REQ-023 cap_start SHALL be ignored outside IDLE; when cap_start and cap_stop arrive in the same IDLE cycle, the FSM SHALL stay in IDLE.
REQ-024 ARM->CAPTURE SHALL occur on vs_rise, with the pixel and line counters cleared; cap_stop in ARM SHALL return the FSM to IDLE on the next edge.
REQ-025 In CAPTURE, cap_stop SHALL set stop_pend; the current frame completes normally.
REQ-026 In CAPTURE, the pixel counter (12 bits, saturating at 4095) SHALL increment on each pix_wr_en.
REQ-027 On href_fall, if the pixel counter is non-zero, the line counter (11 bits, saturating) SHALL increment, line_bad SHALL be set if pixel count != H_PIXEL, and the pixel counter SHALL clear.
REQ-028 In CAPTURE, vs_rise SHALL end the frame: a one-cycle frame_done pulse, frame_cnt+1 (wrapping 255->0), and err_size set if line_bad is set or line count != V_LINE.
REQ-029 At the end of a frame, the FSM SHALL go to IDLE if stop_pend is set, or if frame_num != 0 and the new frame_cnt == frame_num.
REQ-030 Otherwise the FSM SHALL stay in CAPTURE with counters and line_bad cleared, because that same vs_rise starts the next frame.
REQ-031 fifo_wr_en SHALL be registered (1-pclk latency) and equal pix_wr_en & ~fifo_full & (state==CAPTURE).
REQ-032 fifo_wr_data SHALL be pix_data registered on that same edge, and SHALL hold its value otherwise.
REQ-033 If pix_wr_en & fifo_full occurs in CAPTURE, the pixel SHALL be dropped (no write), err_ovf SHALL be set, and the pixel still counts toward geometry.
REQ-034 Pixels and href activity in IDLE or ARM SHALL NOT be written and SHALL NOT be counted.
REQ-035 err_ovf and err_size SHALL hold until the next accepted cap_start or reset.
REQ-036 A frame ending with pending-error conditions and stop at the same time SHALL still report both the error and frame_done.

Reset
REQ-037 Asserting sys_rst_n low SHALL force state IDLE and all outputs, counters and flags to 0 immediately, including mid-frame.
REQ-038 A mid-frame reset SHALL NOT produce frame_done, and no FIFO write SHALL follow it.
REQ-039 After release, the first frame SHALL start only after cap_start plus a fresh vs_rise.

Verification (H_PIXEL=4, V_LINE=2)
REQ-040 Directed: frame_num=1, then cap_start, then a 2x4 frame, then vs_rise -> 8 fifo_wr_en pulses each 1 cycle after pix_wr_en, frame_done once, frame_cnt=1, busy low, no errors.
REQ-041 Directed: frame_num=0, cap_start, 3 frames, then cap_stop mid-frame 3 -> frame_cnt=3 and IDLE only after frame 3's closing vs_rise.
REQ-042 Directed: fifo_full high for 2 pixels in CAPTURE -> 6 writes, err_ovf=1, err_size=0.
REQ-043 Directed: a line carrying 3 pixels -> err_size=1 at frame end while frame_done still pulses; a new cap_start clears err_size.
REQ-044 Directed: cap_start+cap_stop in the same cycle -> busy stays 0; cap_stop in ARM -> IDLE with no writes.
REQ-045 Directed: sys_rst_n low mid-line -> all outputs 0 asynchronously, with no frame_done or fifo_wr_en afterwards.
